frame_writer: RTL and testbench

FRAME_WRITER -- requirements
Module: frame_writer

---
 rtl/frame_writer_if.sv | 25 ++
 rtl/frame_writer.sv | 142 ++++++++++++++
 tb/tb_frame_writer.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_writer_if.sv
// Producer-side port bundle for frame_writer: BRAM write/read port plus the start/busy/done request handshake.
// Handshake: start is honoured only while busy=0 (idle); data is captured on that edge; done pulses once after the flag write.
interface frame_writer_if #(
  parameter int NWORDS = 196
);
  logic                  we;
  logic [7:0]            addr;
  logic [31:0]           din;
  logic [31:0]           dout;
  logic [NWORDS*32-1:0]  data;
  logic                  start;
  logic                  busy;
  logic                  done;
  logic                  timeout;

  modport master (
    output we, addr, din, busy, done, timeout,
    input  dout, data, start
  );

  modport slave (
    input  we, addr, din, busy, done, timeout,
    output dout, data, start
  );
endinterface

// File: rtl/frame_writer.sv
// Publishes an NWORDS x 32-bit frame into a shared BRAM, most significant word first, then sets the flag word.
// Optional FRAME_WRITER_TIMEOUT_EN: abandon the frame after 1024 consecutive non-zero flag polls.
module frame_writer #(
  parameter int         NWORDS    = 196,
  parameter logic [7:0] BASE_ADDR = 8'd0,
  parameter logic [7:0] FLAG_ADDR = 8'd197
) (
  input  logic           clk,
  input  logic           reset,
  frame_writer_if.master bus,
  output logic [2:0]     dbg_state_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    CHECK = 3'd2,
    WRITE = 3'd3,
    FLAG  = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam int         BW       = NWORDS * 32;
  localparam logic [8:0] LAST_IDX = 9'(NWORDS);

  state_t          state_q;
  logic            we_q;
  logic [7:0]      addr_q;
  logic [31:0]     din_q;
  logic            busy_q;
  logic            done_q;
  logic [BW-1:0]   buf_q;
  logic [8:0]      idx_q;
`ifdef FRAME_WRITER_TIMEOUT_EN
  logic [9:0]      tmo_cnt_q;
  logic            timeout_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      addr_q    <= FLAG_ADDR;
      din_q     <= 32'h0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      buf_q     <= '0;
      idx_q     <= 9'd0;
`ifdef FRAME_WRITER_TIMEOUT_EN
      tmo_cnt_q <= 10'd0;
      timeout_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef FRAME_WRITER_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          we_q   <= 1'b0;
          busy_q <= 1'b0;
          if (bus.start) begin
            buf_q   <= bus.data;
            addr_q  <= FLAG_ADDR;
            busy_q  <= 1'b1;
            idx_q   <= 9'd0;
`ifdef FRAME_WRITER_TIMEOUT_EN
            tmo_cnt_q <= 10'd0;
`endif
            state_q <= WAIT;
          end
        end
        WAIT: begin
          addr_q  <= FLAG_ADDR;
          state_q <= CHECK;
        end
        CHECK: begin
          if (bus.dout == 32'h0) begin
            // The buffer shifts left each write, so its top word is always the next word to publish.
            we_q    <= 1'b1;
            addr_q  <= BASE_ADDR;
            din_q   <= buf_q[BW-1 -: 32];
            buf_q   <= buf_q << 32;
            idx_q   <= 9'd1;
            state_q <= WRITE;
          end else begin
            addr_q <= FLAG_ADDR;
            we_q   <= 1'b0;
`ifdef FRAME_WRITER_TIMEOUT_EN
            if (tmo_cnt_q == 10'd1023) begin
              timeout_q <= 1'b1;
              busy_q    <= 1'b0;
              state_q   <= IDLE;
            end else begin
              tmo_cnt_q <= tmo_cnt_q + 10'd1;
            end
`endif
          end
        end
        WRITE: begin
          if (idx_q == LAST_IDX) begin
            addr_q  <= FLAG_ADDR;
            din_q   <= 32'hFFFF_FFFF;
            state_q <= FLAG;
          end else begin
            addr_q <= addr_q + 8'd1;
            din_q  <= buf_q[BW-1 -: 32];
            buf_q  <= buf_q << 32;
            idx_q  <= idx_q + 9'd1;
          end
        end
        FLAG: begin
          we_q    <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          we_q    <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.we      = we_q;
  assign bus.addr    = addr_q;
  assign bus.din     = din_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
`ifdef FRAME_WRITER_TIMEOUT_EN
  assign bus.timeout = timeout_q;
`else
  assign bus.timeout = 1'b0;
`endif
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_frame_writer.sv
// Bench for frame_writer: BRAM model, write scoreboard, latency/flag/reset/back-to-back scenarios.
module tb_frame_writer;
  localparam int         N    = 196;
  localparam int         FW   = N * 32;
  localparam logic [7:0] BASE = 8'd0;
  localparam logic [7:0] FLAG = 8'd197;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] dbg_state;

  frame_writer_if #(.NWORDS(N)) bus();

  frame_writer #(.NWORDS(N), .BASE_ADDR(BASE), .FLAG_ADDR(FLAG)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / edge counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- BRAM model (read-first) with a bench poke port ----------------
  logic [31:0] mem [0:255];
  logic        poke = 1'b0;
  logic [7:0]  poke_addr = FLAG;
  logic [31:0] poke_val = 32'h0;

  always @(posedge clk) begin
    if (bus.we === 1'b1) mem[bus.addr] <= bus.din;
    else if (poke) mem[poke_addr] <= poke_val;
    bus.dout <= mem[bus.addr];
  end

  // ---------------- scoreboard / check ----------------
  logic [39:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  int dwr_cnt = 0, flag_cnt = 0, done_cnt = 0, tmo_cnt = 0;
  int first_edge = -1, flag_edge = -1, done_edge = -1, tmo_edge = -1;
  logic tmo_busy = 1'b1;
  logic [39:0] exp_w;

  // Events are stamped with the edge at which the environment samples them.
  always @(negedge clk) begin
    if (bus.we === 1'b1) begin
      chk("write_queued", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        exp_w = exp_q.pop_front();
        chk("write_addr_data", {bus.addr, bus.din}, exp_w);
      end
      if (bus.addr == FLAG) begin
        flag_cnt++;
        flag_edge = cyc + 1;
      end else begin
        if (bus.addr == BASE) first_edge = cyc + 1;
        dwr_cnt++;
      end
    end
    if (bus.done === 1'b1) begin
      done_cnt++;
      done_edge = cyc + 1;
    end
    if (bus.timeout === 1'b1) begin
      tmo_cnt++;
      tmo_edge = cyc + 1;
      tmo_busy = bus.busy;
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [FW-1:0] rand_frame();
    logic [FW-1:0] r;
    for (int i = 0; i < N; i++) r[i*32 +: 32] = 32'($urandom_range(32'hFFFF_FFFF, 0));
    return r;
  endfunction

  task automatic push_frame(input logic [FW-1:0] d, input int nw);
    for (int i = 0; i < nw; i++) exp_q.push_back({BASE + 8'(i), d[(N-i)*32-1 -: 32]});
    if (nw == N) exp_q.push_back({FLAG, 32'hFFFF_FFFF});
  endtask

  task automatic start_frame(input logic [FW-1:0] d, output int s);
    @(negedge clk);
    bus.data  = d;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    s = cyc;
    bus.start = 1'b0;
  endtask

  task automatic poke_flag(input logic [31:0] v, output int p);
    @(negedge clk);
    poke_addr = FLAG;
    poke_val  = v;
    poke      = 1'b1;
    @(posedge clk);
    #1;
    p    = cyc;
    poke = 1'b0;
  endtask

  task automatic wait_done(input int prev, input int budget, input string tag);
    int k = 0;
    while (done_cnt == prev && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk(tag, 64'(done_cnt != prev), 64'd1);
  endtask

  task automatic chk_timing(input int s);
    chk("first_write_edge", first_edge, s + 3);
    chk("flag_write_edge", flag_edge, s + 3 + N);
    chk("done_edge", done_edge, s + 4 + N);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [FW-1:0] da, db, dc, dd, de, df, dg, dh;
    int s, p, d0, w0, f0, t0, k;

    bus.start = 1'b0;
    bus.data  = '0;
    #1 reset = 1'b1;
    #1;
    chk("rst_we", bus.we, 0);
    chk("rst_addr", bus.addr, FLAG);
    chk("rst_din", bus.din, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_timeout", bus.timeout, 0);
    chk("rst_state", dbg_state, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Frame A: word i = i, flag already clear.
    poke_flag(32'h0, p);
    for (int i = 0; i < N; i++) da[(N-i)*32-1 -: 32] = 32'(i);
    push_frame(da, N);
    start_frame(da, s);
    d0 = done_cnt;
    wait_done(d0, 400, "done_frame_a");
    chk_timing(s);
    chk("mem_word0", mem[0], 0);
    chk("mem_word195", mem[195], 195);
    chk("mem_flag_set", mem[FLAG], 32'hFFFF_FFFF);
    chk("busy_in_done", bus.busy, 0);

    // Frame B back-to-back: start held through the DONE cycle (ignored) and the next (accepted).
    db = rand_frame();
    push_frame(db, N);
    poke_addr = FLAG;
    poke_val  = 32'h0;
    poke      = 1'b1;
    bus.data  = db;
    bus.start = 1'b1;
    @(posedge clk);
    #1 poke = 1'b0;
    @(posedge clk);
    #1 s = cyc;
    bus.start = 1'b0;
    d0 = done_cnt;
    wait_done(d0, 400, "done_frame_b");
    chk_timing(s);

    // Frame C: flag left set for 50 cycles, then cleared by the consumer.
    dc = rand_frame();
    push_frame(dc, N);
    start_frame(dc, s);
    w0 = dwr_cnt;
    repeat (50) @(negedge clk);
    #1;
    chk("no_write_flag_set", dwr_cnt - w0, 0);
    chk("busy_polling", bus.busy, 1);
    poke_flag(32'h0, p);
    d0 = done_cnt;
    wait_done(d0, 400, "done_frame_c");
    chk("first_write_after_clear", first_edge, p + 3);
    chk("flag_edge_c", flag_edge, p + 3 + N);
    chk("done_edge_c", done_edge, p + 4 + N);

    // Frame D: a second start during WRITE with other data must be ignored.
    poke_flag(32'h0, p);
    dd = rand_frame();
    de = rand_frame();
    push_frame(dd, N);
    start_frame(dd, s);
    d0 = done_cnt;
    w0 = dwr_cnt;
    k  = 0;
    while (dwr_cnt - w0 < 10 && k < 100) begin
      @(negedge clk);
      #1;
      k++;
    end
    bus.data  = de;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_done(d0, 400, "done_frame_d");
    chk_timing(s);
    repeat (5) @(negedge clk);
    #1;
    chk("single_done_d", done_cnt - d0, 1);
    chk("idle_busy_d", bus.busy, 0);
    chk("queue_empty_d", exp_q.size(), 0);

    // Frame F: reset at the 100th data write leaves the frame unflagged.
    poke_flag(32'h0, p);
    df = rand_frame();
    push_frame(df, 100);
    start_frame(df, s);
    w0 = dwr_cnt;
    f0 = flag_cnt;
    d0 = done_cnt;
    k  = 0;
    while (dwr_cnt - w0 < 100 && k < 300) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("reached_100th_write", dwr_cnt - w0, 100);
    reset = 1'b1;
    #1;
    chk("async_we_low", bus.we, 0);
    chk("async_busy_low", bus.busy, 0);
    chk("async_state_idle", dbg_state, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("no_flag_write_f", flag_cnt - f0, 0);
    chk("flag_still_clear", mem[FLAG], 0);
    chk("no_done_f", done_cnt - d0, 0);
    chk("queue_empty_f", exp_q.size(), 0);

    // Frame G: restart after reset behaves like a fresh frame.
    dg = rand_frame();
    push_frame(dg, N);
    start_frame(dg, s);
    d0 = done_cnt;
    wait_done(d0, 400, "done_frame_g");
    chk_timing(s);

    // Flag left set after G: timeout behaviour.
    dh = rand_frame();
    t0 = tmo_cnt;
    w0 = dwr_cnt;
    f0 = flag_cnt;
    d0 = done_cnt;
`ifdef FRAME_WRITER_TIMEOUT_EN
    start_frame(dh, s);
    k = 0;
    while (tmo_cnt == t0 && k < 1200) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("timeout_seen", 64'(tmo_cnt != t0), 64'd1);
    chk("timeout_edge", tmo_edge, s + 1026);
    chk("timeout_busy_low", tmo_busy, 0);
    repeat (3) @(negedge clk);
    #1;
    chk("timeout_single", tmo_cnt - t0, 1);
    chk("timeout_no_writes", dwr_cnt - w0, 0);
    chk("timeout_no_flag", flag_cnt - f0, 0);
    chk("timeout_no_done", done_cnt - d0, 0);
    chk("timeout_state_idle", dbg_state, 0);
`else
    push_frame(dh, N);
    start_frame(dh, s);
    repeat (100) @(negedge clk);
    #1;
    chk("no_timeout_default", tmo_cnt - t0, 0);
    chk("still_busy_default", bus.busy, 1);
    chk("no_writes_polling", dwr_cnt - w0, 0);
    poke_flag(32'h0, p);
    wait_done(d0, 400, "done_frame_h");
    chk("first_write_h", first_edge, p + 3);
    chk("done_edge_h", done_edge, p + 4 + N);
`endif

    repeat (3) @(negedge clk);
    chk("queue_empty_end", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
